// File: rtl/axi_lite_pkg.sv
// Shared types for the command-driven AXI4-Lite initiator: response codes and FSM states.
package axi_lite_pkg;

  // AXI response encodings returned on BRESP/RRESP
  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

  // Response code reported when the watchdog fires before the slave answers
  localparam logic [1:0] RESP_TIMEOUT = 2'b11;

  // Transaction sequencer states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_WR_B = 3'd2,
    ST_RD_A = 3'd3,
    ST_RD_R = 3'd4,
    ST_RSP  = 3'd5
  } state_e;

endpackage

// File: rtl/axi_lite_master_wdog.sv
// Transaction watchdog: counts cycles since command accept and pulses expire_o once the
// limit is reached. Only present when AXI_LITE_MASTER_TIMEOUT_EN is defined.
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
module axi_lite_master_wdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic run_i,
  output logic expire_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q;
  logic            expire_q;

  // Count tracks the cycle index after accept; expire is high in cycle TIMEOUT_CYCLES-1
  // so the response it triggers is visible in cycle TIMEOUT_CYCLES.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      expire_q <= 1'b0;
    end else if (clear_i) begin
      cnt_q    <= CntW'(1);
      expire_q <= 1'b0;
    end else if (run_i) begin
      cnt_q    <= cnt_q + CntW'(1);
      expire_q <= ((cnt_q + CntW'(1)) == CntW'(TIMEOUT_CYCLES - 1));
    end else begin
      expire_q <= 1'b0;
    end
  end

  assign expire_o = expire_q;

endmodule
`endif

// File: rtl/axi_lite_master.sv
// Command-driven AXI4-Lite initiator: one read or write command at a time, one response
// per command, at most one outstanding bus transaction.
// Optional watchdog: define AXI_LITE_MASTER_TIMEOUT_EN to enable TIMEOUT_CYCLES expiry.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter logic [2:0]  AXI_PROT       = 3'b000,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  // command / response
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  // AXI4-Lite master port
  output logic [ADDR_WIDTH-1:0]   m0_axi_awaddr,
  output logic [2:0]              m0_axi_awprot,
  output logic                    m0_axi_awvalid,
  input  logic                    m0_axi_awready,
  output logic [DATA_WIDTH-1:0]   m0_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m0_axi_wstrb,
  output logic                    m0_axi_wvalid,
  input  logic                    m0_axi_wready,
  input  logic [1:0]              m0_axi_bresp,
  input  logic                    m0_axi_bvalid,
  output logic                    m0_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m0_axi_araddr,
  output logic [2:0]              m0_axi_arprot,
  output logic                    m0_axi_arvalid,
  input  logic                    m0_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m0_axi_rdata,
  input  logic [1:0]              m0_axi_rresp,
  input  logic                    m0_axi_rvalid,
  output logic                    m0_axi_rready
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;

  state_e                  state_q;
  logic                    cmd_ready_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [StrbW-1:0]        wstrb_q;
  logic                    awvalid_q;
  logic                    wvalid_q;
  logic                    bready_q;
  logic                    arvalid_q;
  logic                    rready_q;
  logic                    rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic [1:0]              rsp_resp_q;
  logic                    to_q;

  logic                    aw_pend_d;
  logic                    w_pend_d;
  logic                    accept_c;
  logic                    rsp_hold_c;
  logic                    bus_busy_c;
  logic                    timeout_c;
  logic                    wdog_expire;

  assign accept_c   = (state_q == ST_IDLE) && cmd_valid && cmd_ready_q;
  assign aw_pend_d  = awvalid_q && !m0_axi_awready;
  assign w_pend_d   = wvalid_q && !m0_axi_wready;
  assign rsp_hold_c = rsp_valid_q && !rsp_ready;

  // A timeout may only replace the response while the slave has not yet answered
  assign bus_busy_c = (state_q == ST_WR) || (state_q == ST_RD_A) ||
                      ((state_q == ST_WR_B) && !m0_axi_bvalid) ||
                      ((state_q == ST_RD_R) && !m0_axi_rvalid);
  assign timeout_c  = wdog_expire && !to_q && bus_busy_c;

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
  logic wdog_run;

  assign wdog_run = (state_q != ST_IDLE) && (state_q != ST_RSP) && !to_q;

  // Cycle counter from accept until the response is produced
  axi_lite_master_wdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (accept_c),
    .run_i    (wdog_run),
    .expire_o (wdog_expire)
  );
`else
  // No watchdog: the block waits on the slave indefinitely
  assign wdog_expire = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

  // Transaction sequencer with all bus and response outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= OKAY;
      to_q        <= 1'b0;
    end else begin
      if (rsp_valid_q && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            cmd_ready_q <= 1'b0;
            addr_q      <= cmd_addr;
            to_q        <= 1'b0;
            if (cmd_write) begin
              wdata_q   <= cmd_wdata;
              wstrb_q   <= cmd_wstrb;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= ST_WR;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= ST_RD_A;
            end
          end
        end
        ST_WR: begin
          awvalid_q <= aw_pend_d;
          wvalid_q  <= w_pend_d;
          if (!aw_pend_d && !w_pend_d) begin
            bready_q <= 1'b1;
            state_q  <= ST_WR_B;
          end
        end
        ST_WR_B: begin
          if (m0_axi_bvalid) begin
            bready_q <= 1'b0;
            if (!to_q) begin
              rsp_valid_q <= 1'b1;
              rsp_resp_q  <= m0_axi_bresp;
              rsp_rdata_q <= '0;
              state_q     <= ST_RSP;
            end else if (rsp_hold_c) begin
              state_q <= ST_RSP;
            end else begin
              to_q        <= 1'b0;
              cmd_ready_q <= 1'b1;
              state_q     <= ST_IDLE;
            end
          end
        end
        ST_RD_A: begin
          if (m0_axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_RD_R;
          end
        end
        ST_RD_R: begin
          if (m0_axi_rvalid) begin
            rready_q <= 1'b0;
            if (!to_q) begin
              rsp_valid_q <= 1'b1;
              rsp_resp_q  <= m0_axi_rresp;
              rsp_rdata_q <= m0_axi_rdata;
              state_q     <= ST_RSP;
            end else if (rsp_hold_c) begin
              state_q <= ST_RSP;
            end else begin
              to_q        <= 1'b0;
              cmd_ready_q <= 1'b1;
              state_q     <= ST_IDLE;
            end
          end
        end
        ST_RSP: begin
          if (rsp_ready) begin
            to_q        <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
      if (timeout_c) begin
        rsp_valid_q <= 1'b1;
        rsp_resp_q  <= RESP_TIMEOUT;
        rsp_rdata_q <= '0;
        to_q        <= 1'b1;
      end
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_resp       = rsp_resp_q;
  assign m0_axi_awaddr  = addr_q;
  assign m0_axi_awprot  = AXI_PROT;
  assign m0_axi_awvalid = awvalid_q;
  assign m0_axi_wdata   = wdata_q;
  assign m0_axi_wstrb   = wstrb_q;
  assign m0_axi_wvalid  = wvalid_q;
  assign m0_axi_bready  = bready_q;
  assign m0_axi_araddr  = addr_q;
  assign m0_axi_arprot  = AXI_PROT;
  assign m0_axi_arvalid = arvalid_q;
  assign m0_axi_rready  = rready_q;

endmodule
